mul_iter_32b: RTL

// - Multi-cycle 32-bit integer multiplier responder for the TinyRV1 execute stage.
// - Returns the low 32 bits of in0*in1 (TinyRV1 mul semantics); sign-agnostic.
// - Single-cycle counterpart is ALU_32b (add/eq).
// - Operands arrive on a val/rdy request stream; the product leaves on a val/rdy response

---
 rtl/mul_iter_pkg.sv | 18 +
 rtl/mul_iter_32b_alu.sv | 19 +
 rtl/mul_iter_32b.sv | 109 ++++++++++
 3 files changed

// File: rtl/mul_iter_pkg.sv
// Shared types and constants for the iterative 32-bit multiplier.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mul_iter_pkg;

  // Control states: waiting for operands, iterating, holding the product.
  typedef enum logic [1:0] {IDLE, CALC, DONE} mul_state_t;

  // One shift-add step per multiplier bit.
  localparam int NITER = 32;

  // Counter wide enough to index every iteration.
  localparam int CNT_W = $clog2(NITER);

  // Count value seen on the final iteration.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NITER - 1);

endpackage

// File: rtl/mul_iter_32b_alu.sv
// Single-cycle 32-bit ALU: op=0 add (wraps mod 2^32), op=1 equality compare.
// Latency: combinational.
// Backpressure: none; no handshake.
module ALU_32b (
  input  logic [31:0] in0,
  input  logic [31:0] in1,
  input  logic        op,
  output logic [31:0] out
);

  // Add by default; equality result lands in bit 0 when op is set.
  always_comb begin
    out = in0 + in1;
    if (op) begin
      out = {31'd0, (in0 == in1)};
    end
  end

endmodule

// File: rtl/mul_iter_32b.sv
// Iterative shift-add multiplier returning the low 32 bits of in0*in1.
// Latency: 32 CALC edges (EARLY_EXIT=0) or 1 + msb index of in1 (EARLY_EXIT=1).
// Backpressure: request accepted only in IDLE; product held stable in DONE until ostream_rdy.
module mul_iter_32b
  import mul_iter_pkg::*;
#(
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        istream_val,
  output logic        istream_rdy,
  input  logic [31:0] istream_in0,
  input  logic [31:0] istream_in1,
  output logic        ostream_val,
  input  logic        ostream_rdy,
  output logic [31:0] ostream_out
);

  mul_state_t       state;
  mul_state_t       state_nxt;

  logic [31:0]      a_reg;
  logic [31:0]      b_reg;
  logic [31:0]      acc;
  logic [31:0]      alu_out;
  logic [CNT_W-1:0] count;
  logic             last_iter;
  logic             accept;

  // The early-exit test looks at the multiplier after this edge's shift.
  assign last_iter = (count == LAST_CNT) ||
                     (EARLY_EXIT && (b_reg[31:1] == 31'd0));

  // Operands are captured only on a real handshake, so idle-time X never enters state.
  assign accept = (state == IDLE) && istream_val;

  // Accumulation goes through the shared ALU in add mode.
  ALU_32b u_alu (
    .in0 (acc),
    .in1 (a_reg),
    .op  (1'b0),
    .out (alu_out)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt   = state;
    istream_rdy = 1'b0;
    ostream_val = 1'b0;
    case (state)
      IDLE: begin
        istream_rdy = 1'b1;
        if (istream_val) begin
          state_nxt = CALC;
        end
      end
      CALC: begin
        if (last_iter) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        ostream_val = 1'b1;
        if (ostream_rdy) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath: load on accept, one shift-add step per CALC edge, hold otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg <= 32'd0;
      b_reg <= 32'd0;
      acc   <= 32'd0;
      count <= '0;
    end else if (accept) begin
      a_reg <= istream_in0;
      b_reg <= istream_in1;
      acc   <= 32'd0;
      count <= '0;
    end else if (state == CALC) begin
      if (b_reg[0]) begin
        acc <= alu_out;
      end
      a_reg <= {a_reg[30:0], 1'b0};
      b_reg <= {1'b0, b_reg[31:1]};
      count <= count + CNT_W'(1);
    end
  end

  // The product is whatever the accumulator holds; zero right after a clear.
  assign ostream_out = acc;

endmodule
